// File: rtl/level_manager_if.sv
// Handshake bundle between the frogger top level and level_manager.
// The score signal exists only when LEVEL_MANAGER_SCORE_EN is defined.
interface level_manager_if #(
    parameter int LEVEL_W   = 4,
    parameter int LIVES_W   = 2,
    parameter int NUM_LANES = 8,
    parameter int SPEED_W   = 8
);
    logic                         frame_tick;
    logic                         death_collision;
    logic                         win_collision;
    logic                         restart_req;
    logic                         round_reset;
    logic [LEVEL_W-1:0]           current_level;
    logic [LIVES_W-1:0]           lives;
    logic                         game_over;
    logic                         level_wrap;
    logic [NUM_LANES*SPEED_W-1:0] lane_speed;
`ifdef LEVEL_MANAGER_SCORE_EN
    logic [15:0]                  score;
`endif

    modport master (
        output frame_tick, death_collision, win_collision, restart_req,
        input  round_reset, current_level, lives, game_over, level_wrap,
`ifdef LEVEL_MANAGER_SCORE_EN
        input  score,
`endif
        input  lane_speed
    );

    modport slave (
        input  frame_tick, death_collision, win_collision, restart_req,
        output round_reset, current_level, lives, game_over, level_wrap,
`ifdef LEVEL_MANAGER_SCORE_EN
        output score,
`endif
        output lane_speed
    );
endinterface

// File: rtl/level_manager.sv
// Frogger game-progression controller: level, lives, pauses, lane speeds.
// Optional score output enabled by defining LEVEL_MANAGER_SCORE_EN.
module level_manager #(
    parameter int NUM_LEVELS   = 10,
    parameter int LEVEL_W      = 4,
    parameter int NUM_LIVES    = 3,
    parameter int LIVES_W      = 2,
    parameter int PAUSE_FRAMES = 30,
    parameter int NUM_LANES    = 8,
    parameter int SPEED_W      = 8,
    parameter int BASE_SPEED   = 20,
    parameter int LANE_STEP    = 5,
    parameter int LEVEL_STEP   = 4,
    parameter int SPEED_MAX    = 200
) (
    input logic clk,
    input logic reset,
    level_manager_if.slave bus
);
    typedef enum logic [1:0] {
        PLAY, PAUSE_WIN, PAUSE_DEATH, GAME_OVER
    } state_t;

    localparam int CNT_W = $clog2(PAUSE_FRAMES + 2);
    localparam int CW    = SPEED_W + LEVEL_W + 16;
    localparam logic [CNT_W-1:0]   PAUSE_END   = CNT_W'(PAUSE_FRAMES);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL  = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [LIVES_W-1:0] START_LIVES = LIVES_W'(NUM_LIVES);

    state_t             state, state_n;
    logic [LEVEL_W-1:0] level, level_n;
    logic [LIVES_W-1:0] lives, lives_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               wrap, wrap_n;
    logic               rnd_rst, over;
    logic               hist_death, hist_win, hist_restart;
    logic               death_ev, win_ev, restart_ev;
    logic [NUM_LANES*SPEED_W-1:0] speeds;

    function automatic logic [NUM_LANES*SPEED_W-1:0] table_of(
        input logic [LEVEL_W-1:0] lvl
    );
        logic [NUM_LANES*SPEED_W-1:0] t;
        logic [CW-1:0]                raw;
        t = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            raw = CW'(BASE_SPEED) + CW'(i * LANE_STEP)
                + CW'(lvl) * CW'(LEVEL_STEP);
            t[i*SPEED_W +: SPEED_W] = (raw > CW'(SPEED_MAX))
                ? SPEED_W'(SPEED_MAX) : raw[SPEED_W-1:0];
        end
        return t;
    endfunction

    assign death_ev   = bus.death_collision & ~hist_death;
    assign win_ev     = bus.win_collision & ~hist_win;
    assign restart_ev = bus.restart_req & ~hist_restart;

`ifdef LEVEL_MANAGER_SCORE_EN
    logic [15:0] score, score_n;
    logic [31:0] score_sum;
    assign score_sum = 32'(score) + 32'(level) * 32'd10 + 32'd10;
    assign bus.score = score;
`endif

    always_comb begin
        state_n = state;
        level_n = level;
        lives_n = lives;
        cnt_n   = cnt;
        wrap_n  = 1'b0;
`ifdef LEVEL_MANAGER_SCORE_EN
        score_n = score;
`endif
        if (restart_ev) begin
            state_n = PAUSE_DEATH;
            level_n = '0;
            lives_n = START_LIVES;
            cnt_n   = '0;
`ifdef LEVEL_MANAGER_SCORE_EN
            score_n = '0;
`endif
        end else begin
            unique case (state)
                PLAY: begin
                    cnt_n = '0;
                    if (death_ev) begin
                        lives_n = lives - LIVES_W'(1);
                        state_n = (lives == LIVES_W'(1)) ? GAME_OVER
                                                         : PAUSE_DEATH;
                    end else if (win_ev) begin
                        state_n = PAUSE_WIN;
                        if (level == LAST_LEVEL) begin
                            level_n = '0;
                            wrap_n  = 1'b1;
                        end else begin
                            level_n = level + LEVEL_W'(1);
                        end
`ifdef LEVEL_MANAGER_SCORE_EN
                        score_n = (|score_sum[31:16]) ? 16'hFFFF
                                                      : score_sum[15:0];
`endif
                    end
                end
                PAUSE_WIN, PAUSE_DEATH: begin
                    // Compare before counting so a tick on the last
                    // cycle cannot push the counter past its end value.
                    if (cnt == PAUSE_END) begin
                        state_n = PLAY;
                    end else if (bus.frame_tick) begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                GAME_OVER: begin
                    state_n = GAME_OVER;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= PLAY;
            level        <= '0;
            lives        <= START_LIVES;
            cnt          <= '0;
            wrap         <= 1'b0;
            rnd_rst      <= 1'b1;
            over         <= 1'b0;
            hist_death   <= 1'b1;
            hist_win     <= 1'b1;
            hist_restart <= 1'b1;
            speeds       <= table_of('0);
`ifdef LEVEL_MANAGER_SCORE_EN
            score        <= '0;
`endif
        end else begin
            state        <= state_n;
            level        <= level_n;
            lives        <= lives_n;
            cnt          <= cnt_n;
            wrap         <= wrap_n;
            rnd_rst      <= (state_n != PLAY);
            over         <= (state_n == GAME_OVER);
            hist_death   <= bus.death_collision;
            hist_win     <= bus.win_collision;
            hist_restart <= bus.restart_req;
            speeds       <= table_of(level);
`ifdef LEVEL_MANAGER_SCORE_EN
            score        <= score_n;
`endif
        end
    end

    assign bus.round_reset   = rnd_rst;
    assign bus.current_level = level;
    assign bus.lives         = lives;
    assign bus.game_over     = over;
    assign bus.level_wrap    = wrap;
    assign bus.lane_speed    = speeds;
endmodule
